serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial unsigned subtractor: computes diff = a - b, LSB first, one bit per clock.
//   Uses a full-subtractor cell with a registered borrow.
//   Inverse-operation companion to the 1-bit adder cells; area-cheap arithmetic for lab datapaths.
//   Controlled by a start/busy/done handshake from a sequencing FSM or testbench.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//   clk     in   1      single clock, rising-edge
//   rst_n   in   1      reset, asynchronous assert, active-low
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  minuend; captured on accepted start
//   b       in   WIDTH  subtrahend; captured on accepted start
//   busy    out  1      high while an operation is in progress (RUN)
//   done    out  1      one-cycle pulse; diff/borrow valid
//   diff    out  WIDTH  (a - b) mod 2^WIDTH
//   borrow  out  1      final borrow-out; 1 iff a < b (unsigned)
// BEHAVIOUR
//   Clock and reset
//   - One clock; reset is asynchronous and active-low.
//   - Reset (rst_n=0): state=IDLE; busy=0, done=0, diff=0, borrow=0.
//   - Reset also clears the operand shift registers and the bit counter.
//   FSM states: IDLE -> RUN -> DONE -> IDLE
//   - IDLE, start=1 at edge E0: capture a, b into shift regs, clear borrow reg, cnt=0.
//     -> RUN; busy=1 after E0.
//   - IDLE, start=0: hold; diff and borrow keep their last values.
//   - RUN, each edge: process bit i = cnt, with sa=a_sh[0], sb=b_sh[0], br=borrow reg.
//       d      = sa ^ sb ^ br
//       br_nxt = (~sa & sb) | (~(sa ^ sb) & br)
//     Shift d into diff MSB (diff shifts right); shift a_sh and b_sh right; cnt++.
//     After WIDTH RUN edges (E1..E_WIDTH), diff holds all WIDTH result bits.
//     On edge E_WIDTH: borrow <= br_nxt; -> DONE.
//   - DONE: done=1, busy=0 for exactly one cycle. Next edge -> IDLE, done=0.
//   Latency and result validity
//   - Latency: start sampled at E0 -> done high in the cycle after E_WIDTH (WIDTH+1 edges).
//   - diff/borrow: partial while busy; valid from done assertion.
//     They hold until the next accepted start or reset.
//   Handshake rules
//   - start is ignored in RUN and DONE (no queuing).
//     Back-to-back operation with start held high: a new op is accepted on the edge that
//     leaves... no — accepted on the first IDLE edge, i.e. period WIDTH+2 cycles.
//   - a/b changes after capture have no effect on the running operation.
//   - busy and done are never both high; done never asserts without a prior accepted start.
//   Boundaries
//   - a == b: diff=0, borrow=0.
//   - a=0, b=1: borrow propagates through all bits; diff = all ones, borrow=1.
//   - Wrap-around: diff is always modulo 2^WIDTH; no saturation.
//   - Reset mid-RUN or in DONE: abort immediately; outputs to reset values; no done pulse.
//     The next start after reset release runs normally.
//   - cnt width: $clog2(WIDTH+1); no overflow possible.
// TESTING (WIDTH=8 unless noted; golden model = (a - b) & mask, borrow = a < b)
//   1. a=8'h05, b=8'h03, start 1 cycle -> busy for 8 cycles; done 9 edges after start;
//      diff=8'h02, borrow=0.
//   2. a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1. Also a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1.
//   3. a=b=8'hA5 -> diff=8'h00, borrow=0. Also a=8'hFF, b=8'h00 -> diff=8'hFF, borrow=0.
//   4. start held high for 40 cycles; a/b toggled mid-op -> ops every WIDTH+2 cycles;
//      each result uses the operands captured at its accept edge; start while busy ignored.
//   5. rst_n pulsed low asynchronously (between edges) at RUN bit 4 -> outputs 0 at once;
//      no done; subsequent op a=8'h10, b=8'h01 -> diff=8'h0F, borrow=0.
//   6. WIDTH=4 exhaustive: all 256 (a,b) pairs vs golden model; checked every done;
//      busy/done never both high (assertion).

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// using a full-subtractor cell with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic sa;
    logic sb;
    logic d_bit;
    logic br_nxt;

    // Full-subtractor cell on the current LSBs and the carried-in borrow.
    assign sa     = a_sh_reg[0];
    assign sb     = b_sh_reg[0];
    assign d_bit  = sa ^ sb ^ br_reg;
    assign br_nxt = (~sa & sb) | (~(sa ^ sb) & br_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    diff     <= {d_bit, diff[WIDTH-1:1]};
                    a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    br_reg   <= br_nxt;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        borrow    <= br_nxt;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances)
// against an arithmetic reference: diff = (a - b) mod 2^W, borrow = (a < b).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    // busy and done must never be high together on either instance.
    always @(negedge clk) begin
        if (rst_n && ((busy8 && done8) || (busy4 && done4))) begin
            errors++;
            $display("FAIL busy_done_overlap: busy8=%0b done8=%0b busy4=%0b done4=%0b required not both high",
                     busy8, done8, busy4, done4);
        end
    end

    // Drive one single-cycle start on the WIDTH=8 instance and wait (bounded) for done.
    // Returns at the negedge after the DONE cycle, so the DUT is back in IDLE.
    task automatic do_op8(input logic [7:0] a_in, input logic [7:0] b_in,
                          output logic [7:0] d_out, output logic br_out,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        a8 = a_in; b8 = b_in; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a_in; b8 = ~b_in;
        lat = 1;
        busy_cycles = 0;
        while (!done8 && lat < 30) begin
            if (busy8) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        d_out  = diff8;
        br_out = borrow8;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b diff=%h borrow=%0b required all 0",
                     busy8, done8, diff8, borrow8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy8, done8, busy4, done4} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: busy8=%0b done8=%0b busy4=%0b done4=%0b required 0",
                     busy8, done8, busy4, done4);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d; logic br; int lat, bc;
        do_op8(8'h05, 8'h03, d, br, lat, bc);
        $display("op a=05 b=03 -> diff=%h borrow=%0b lat=%0d busy=%0d", d, br, lat, bc);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 9", lat);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required 8", bc);
        end
        checks++;
        if (d !== 8'h02 || br !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %h/%0b required 02/0", d, br);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] va [4] = '{8'h03, 8'h00, 8'hA5, 8'hFF};
        logic [7:0] vb [4] = '{8'h05, 8'h01, 8'hA5, 8'h00};
        logic [7:0] ed [4] = '{8'hFE, 8'hFF, 8'h00, 8'hFF};
        logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] d; logic br; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            do_op8(va[i], vb[i], d, br, lat, bc);
            $display("op a=%h b=%h -> diff=%h borrow=%0b", va[i], vb[i], d, br);
            checks++;
            if (d !== ed[i] || br !== eb[i] || lat !== 9) begin
                errors++;
                $display("FAIL boundary_%0d: got %h/%0b lat %0d required %h/%0b lat 9",
                         i, d, br, lat, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, d, exp_d; logic br, exp_b; int lat, bc;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            exp_d = 8'((int'(ra) - int'(rb) + 256) % 256);
            exp_b = (ra < rb);
            do_op8(ra, rb, d, br, lat, bc);
            $display("op a=%h b=%h -> diff=%h borrow=%0b", ra, rb, d, br);
            checks++;
            if (d !== exp_d || br !== exp_b || lat !== 9) begin
                errors++;
                $display("FAIL random_%0d: got %h/%0b lat %0d required %h/%0b lat 9",
                         i, d, br, lat, exp_d, exp_b);
            end
        end
    endtask

    // start held high with operands changing every cycle: accepts every 10 edges,
    // each result built from the operands present at its accept edge.
    task automatic test_back_to_back();
        logic [7:0] opa [40];
        logic [7:0] opb [40];
        logic [7:0] exp_d; logic exp_b, exp_done, exp_busy;
        int k;
        for (int n = 0; n < 40; n++) begin
            opa[n] = 8'($urandom); opb[n] = 8'($urandom);
            a8 = opa[n]; b8 = opb[n]; start8 = 1'b1;
            @(negedge clk);
            exp_done = (n % 10 == 8);
            exp_busy = (n % 10 < 8);
            checks++;
            if (done8 !== exp_done || busy8 !== exp_busy) begin
                errors++;
                $display("FAIL b2b_handshake_%0d: busy/done got %0b/%0b required %0b/%0b",
                         n, busy8, done8, exp_busy, exp_done);
            end
            if (exp_done) begin
                k = n - 8;
                exp_d = 8'((int'(opa[k]) - int'(opb[k]) + 256) % 256);
                exp_b = (opa[k] < opb[k]);
                $display("b2b op a=%h b=%h -> diff=%h borrow=%0b", opa[k], opb[k], diff8, borrow8);
                checks++;
                if (diff8 !== exp_d || borrow8 !== exp_b) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %h/%0b required %h/%0b",
                             n, diff8, borrow8, exp_d, exp_b);
                end
            end
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d; logic br; int lat, bc;
        bit seen_done;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'b0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: busy=%0b done=%0b diff=%h borrow=%0b required all 0",
                     busy8, done8, diff8, borrow8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen_done = 1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midrun_no_done: got activity after reset, required none");
        end
        do_op8(8'h10, 8'h01, d, br, lat, bc);
        $display("op a=10 b=01 -> diff=%h borrow=%0b", d, br);
        checks++;
        if (d !== 8'h0F || br !== 1'b0 || lat !== 9) begin
            errors++;
            $display("FAIL after_reset_op: got %h/%0b lat %0d required 0f/0 lat 9", d, br, lat);
        end
    endtask

    task automatic test_width4_exhaustive();
        logic [3:0] exp_d; logic exp_b; int lat; int bad;
        bad = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                @(negedge clk);
                a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                lat = 1;
                while (!done4 && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                exp_d = 4'((ia - ib + 16) % 16);
                exp_b = (ia < ib);
                checks++;
                if (diff4 !== exp_d || borrow4 !== exp_b || lat !== 5) begin
                    errors++;
                    bad++;
                    $display("FAIL w4_a%0d_b%0d: got %h/%0b lat %0d required %h/%0b lat 5",
                             ia, ib, diff4, borrow4, lat, exp_d, exp_b);
                end
                @(negedge clk);
            end
        end
        $display("w4 exhaustive: 256 ops, %0d bad", bad);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_width4_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
